// File: rtl/ram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// ram_arb_ctrl : two-port round-robin arbiter driving one single-port RAM
//                with a registered read path.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_arb_ctrl #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_cs,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RCAP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          port_q, port_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ram_cs_q, ram_cs_d;
  logic          ram_rd_q, ram_rd_d;
  logic          ram_wr_q, ram_wr_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          win;
  logic          win_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      port_q      <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ram_cs_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      port_q      <= port_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ram_cs_q    <= ram_cs_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    port_d      = port_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ram_cs_d    = 1'b0;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    // On a tie the port that did not win last time goes first.
    win         = (req0 && req1) ? ~last_gnt_q : req1;
    win_we      = win ? we1 : we0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          last_gnt_d  = win;
          port_d      = win;
          gnt0_d      = ~win;
          gnt1_d      = win;
          ram_cs_d    = 1'b1;
          ram_wr_d    = win_we;
          ram_rd_d    = ~win_we;
          ram_addr_d  = win ? addr1 : addr0;
          ram_wdata_d = win ? wdata1 : wdata0;
          state_d     = ACC;
        end
      end
      ACC: begin
        state_d = ram_rd_q ? RCAP : IDLE;
      end
      RCAP: begin
        if (port_q) begin
          rdata1_d  = ram_rdata;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = ram_rdata;
          rvalid0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ram_cs    = ram_cs_q;
  assign ram_rd    = ram_rd_q;
  assign ram_wr    = ram_wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_arb_ctrl : directed bench for ram_arb_ctrl with a registered-read
//                   RAM model.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_arb_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_cs, ram_rd, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arb_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM: write and read sampled at the edge, read data next cycle.
  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_rd) ram_rdata <= mem[ram_addr];
  end

  // Structural invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      assert (!(ram_rd && ram_wr) && (!(ram_rd || ram_wr) || ram_cs) &&
              !(gnt0 && gnt1) && !(rvalid0 && rvalid1))
      else begin
        n_err++;
        $error("FAIL invariant: observed rd=%0b wr=%0b cs=%0b gnt=%0b%0b rv=%0b%0b expected exclusive",
               ram_rd, ram_wr, ram_cs, gnt0, gnt1, rvalid0, rvalid1);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  task automatic drop(input logic p);
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // gnt/cs/rd/wr as one vector {gnt0,gnt1,cs,rd,wr}
  task automatic do_write(input logic p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(p, 1'b1, a, d);
    step();
    chk("wr_ctl", {gnt0, gnt1, ram_cs, ram_rd, ram_wr}, {~p, p, 3'b101});
    chk("wr_addr", ram_addr, a);
    chk("wr_data", ram_wdata, d);
    drop(p);
    step();
    chk("wr_acc_clr", {gnt0, gnt1, ram_cs, ram_rd, ram_wr}, 5'b00000);
  endtask

  task automatic do_read(input logic p, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    drive(p, 1'b0, a, '0);
    step();
    chk("rd_ctl", {gnt0, gnt1, ram_cs, ram_rd, ram_wr}, {~p, p, 3'b110});
    chk("rd_addr", ram_addr, a);
    drop(p);
    step();
    chk("rd_acc_clr", {gnt0, gnt1, ram_cs, ram_rd, ram_wr, rvalid0, rvalid1}, 7'b0);
    step();
    chk("rd_rvalid", {rvalid0, rvalid1}, {~p, p});
    chk("rd_rdata", p ? rdata1 : rdata0, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {gnt0, gnt1, rvalid0, rvalid1, ram_cs, ram_rd, ram_wr}, 7'b0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_rdata"}, {rdata0, rdata1}, 0);
  endtask

  initial begin
    // Reset is asynchronous: outputs are 0 before any clock edge.
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_noreq", {gnt0, gnt1, ram_cs, ram_rd, ram_wr}, 5'b0);

    // Port 1 alone: boundary addresses 0x3FF and 0x000.
    do_write(1'b1, 10'h3FF, 8'hFF);
    do_write(1'b1, 10'h000, 8'h00);
    do_read(1'b1, 10'h3FF, 8'hFF);
    do_read(1'b1, 10'h000, 8'h00);
    chk("p1_rdata0_untouched", rdata0, 8'h00);

    // Port 0 write then read back.
    do_write(1'b0, 10'h005, 8'hA5);
    do_read(1'b0, 10'h005, 8'hA5);
    step();
    chk("rvalid_one_cycle", {rvalid0, rvalid1}, 2'b00);
    chk("rdata0_held", rdata0, 8'hA5);
    chk("rdata1_held", rdata1, 8'h00);

    // Both ports write continuously from reset: 0,1,0,1 every 2 cycles.
    rst = 1'b1;
    #1;
    chk("rst_mid_run_rdata0", rdata0, 8'h00);
    rst = 1'b0;
    drive(1'b0, 1'b1, 10'h010, 8'h11);
    drive(1'b1, 1'b1, 10'h020, 8'h22);
    step(); chk("rr_e1", {gnt0, gnt1}, 2'b10);
    step(); chk("rr_e2", {gnt0, gnt1}, 2'b00);
    step(); chk("rr_e3", {gnt0, gnt1}, 2'b01);
    chk("rr_e3_addr", ram_addr, 10'h020);
    step(); chk("rr_e4", {gnt0, gnt1}, 2'b00);
    step(); chk("rr_e5", {gnt0, gnt1}, 2'b10);
    step(); chk("rr_e6", {gnt0, gnt1}, 2'b00);
    step(); chk("rr_e7", {gnt0, gnt1}, 2'b01);
    drop(1'b0);
    drop(1'b1);
    step();

    // After a port-0 grant, simultaneous port-0 read and port-1 write.
    do_write(1'b0, 10'h030, 8'h5A);
    drive(1'b0, 1'b0, 10'h030, 8'h00);
    drive(1'b1, 1'b1, 10'h031, 8'hC3);
    step();
    chk("sim_first", {gnt0, gnt1, ram_cs, ram_rd, ram_wr}, 5'b01101);
    drop(1'b1);
    step();
    chk("sim_acc", {gnt0, gnt1, ram_cs, ram_rd, ram_wr}, 5'b00000);
    step();
    chk("sim_second", {gnt0, gnt1, ram_cs, ram_rd, ram_wr}, 5'b10110);
    drop(1'b0);
    step();
    step();
    chk("sim_rvalid", {rvalid0, rvalid1}, 2'b10);
    chk("sim_rdata", rdata0, 8'h5A);

    // Reset while in RCAP abandons the read.
    drive(1'b0, 1'b0, 10'h005, 8'h00);
    step();
    chk("mid_gnt", {gnt0, ram_rd}, 2'b11);
    drop(1'b0);
    step();
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_quiet", {rvalid0, rvalid1, ram_cs, ram_rd, ram_wr}, 5'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
